// File: rtl/acc_mem_responder.sv
// Target side of the accelerator memory bus: word RAM plus a host job sequencer (load, start, run, dump).
// Optional `ACC_MEM_BOUNDS_CHK_EN builds a sticky out-of-range flag on err; otherwise err is tied low.
module acc_mem_responder #(
  parameter int DEPTH       = 50688,
  parameter int SRC_WORDS   = 25344,
  parameter int RESULT_BASE = 25344,
  parameter int RES_WORDS   = 25344
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  output logic [31:0] dataR,
  input  logic [31:0] dataW,
  input  logic        en,
  input  logic        we,
  output logic        start,
  input  logic        finish,
  input  logic        go,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [31:0] cycles,
  output logic        busy,
  output logic        err
);

  localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
  localparam logic [15:0] SRC_LAST = 16'(SRC_WORDS - 1);
  localparam logic [15:0] RES_LAST = 16'(RES_WORDS - 1);
  localparam logic [15:0] RES_BASE = 16'(RESULT_BASE);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_RD, DUMP_OUT, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] ptr, dptr, ram_addr;
  logic [31:0] ram_wd, ram_rd;
  logic        ram_we, in_range;
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx   = state;
    ld_ready   = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        if (go) state_nx = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ptr == SRC_LAST) state_nx = RUN;
      end
      // finish is only honoured once the start pulse has gone
      RUN:      if (!start && finish) state_nx = DUMP_RD;
      DUMP_RD:  state_nx = DUMP_OUT;
      DUMP_OUT: begin
        dump_valid = 1'b1;
        if (dump_ready) state_nx = (dptr == RES_LAST) ? DONE : DUMP_RD;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // Single RAM port, owned by whichever agent the current state serves.
  always_comb begin
    ram_addr = addr;
    ram_wd   = dataW;
    ram_we   = 1'b0;
    case (state)
      LOAD: begin
        ram_addr = ptr;
        ram_wd   = ld_data;
        ram_we   = ld_valid;
      end
      RUN:     ram_we = en && we;
      DUMP_RD: ram_addr = RES_BASE + dptr;
      default: ;
    endcase
    in_range = {1'b0, ram_addr} < DEPTH_W;
    ram_rd   = in_range ? mem[ram_addr[IW-1:0]] : 32'd0;
  end

  always_ff @(posedge clk)
    if (ram_we && in_range) mem[ram_addr[IW-1:0]] <= ram_wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      dptr      <= '0;
      start     <= 1'b0;
      cycles    <= '0;
      dataR     <= '0;
      dump_data <= '0;
    end else begin
      start <= (state == LOAD) && (state_nx == RUN);
      case (state)
        IDLE, DONE: if (go) ptr <= '0;
        LOAD: begin
          if (ld_valid) ptr <= ptr + 16'd1;
          if (state_nx == RUN) cycles <= '0;
        end
        RUN: begin
          if (cycles != '1) cycles <= cycles + 32'd1;
          if (en && !we) dataR <= ram_rd;
          if (state_nx == DUMP_RD) dptr <= '0;
        end
        DUMP_RD:  dump_data <= ram_rd;
        DUMP_OUT: if (dump_ready) dptr <= dptr + 16'd1;
        default: ;
      endcase
    end
  end

`ifdef ACC_MEM_BOUNDS_CHK_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) err <= 1'b0;
    else if (((state == RUN) && en) || ((state == LOAD) && ld_valid))
      if (!in_range) err <= 1'b1;
`else
  assign err = 1'b0;
`endif

endmodule
